ysyx_23060111_seq: RTL

Multi-cycle instruction sequencer for the ysyx_23060111 core, replacing the single-cycle top-level control where fetch, execute and memory access all complete in one clock. The block owns the PC, holds the fetched instruction stable for IDU/EXU, and steps each instruction through fetch → execute → memory → writeback. Each phase uses valid/ready handshakes so IFU and LSU may have arbitrary latency. The block also provides a bus-timeout watchdog, a halt/cause report and a retired-instruction counter.

---
 rtl/ysyx_23060111_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060111_seq.sv
// rtl/ysyx_23060111_seq.sv - multi-cycle fetch/execute/memory/writeback sequencer with bus watchdog
module ysyx_23060111_seq #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255,
    parameter int          TO_W     = 8,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [XLEN-1:0]  ifu_addr,
    input  logic             ifu_rsp_valid,
    input  logic [31:0]      ifu_rsp_data,
    output logic             ifu_rsp_ready,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  exu_dnpc,
    input  logic             exu_mem,
    input  logic             exu_inv,
    input  logic             exu_ebreak,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    output logic             wb_en,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        F_REQ  = 3'd0,
        F_WAIT = 3'd1,
        EXEC   = 3'd2,
        M_REQ  = 3'd3,
        M_WAIT = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [1:0]      CAUSE_EBREAK  = 2'd1;
    localparam logic [1:0]      CAUSE_INVALID = 2'd2;
    localparam logic [1:0]      CAUSE_TIMEOUT = 2'd3;
    localparam logic [TO_W-1:0] TO_VAL        = TO_W'(TIMEOUT);
    localparam bit              WDOG_ON       = (TIMEOUT != 0);

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_inst;
    logic [CNT_W-1:0]  r_instret;
    logic [1:0]        r_cause;
    logic [TO_W-1:0]   r_wdog;
    logic              r_ifu_req_valid;
    logic              r_ifu_rsp_ready;
    logic              r_lsu_req_valid;
    logic              r_wb_en;
    logic              r_halted;

    state_t            w_next;
    logic [1:0]        w_cause;
    logic              w_expired;
    logic              w_bus_state;
    logic              w_wdog_clear;

    // The watchdog only fires when its count has reached the limit; callers
    // still check their own exit condition first so a late response wins.
    assign w_expired   = WDOG_ON && (r_wdog == TO_VAL);
    assign w_bus_state = (r_state == F_REQ) || (r_state == F_WAIT) ||
                         (r_state == M_REQ) || (r_state == M_WAIT);

    // Next-state and halt-cause selection; responses only count in WAIT states.
    always_comb begin
        w_next  = r_state;
        w_cause = r_cause;
        case (r_state)
            F_REQ: begin
                if (ifu_req_ready) begin
                    w_next = F_WAIT;
                end else if (w_expired) begin
                    w_next  = HALT;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            F_WAIT: begin
                if (ifu_rsp_valid) begin
                    w_next = EXEC;
                end else if (w_expired) begin
                    w_next  = HALT;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            EXEC: begin
                if (exu_inv) begin
                    w_next  = HALT;
                    w_cause = CAUSE_INVALID;
                end else if (exu_ebreak) begin
                    w_next  = HALT;
                    w_cause = CAUSE_EBREAK;
                end else if (exu_mem) begin
                    w_next = M_REQ;
                end else begin
                    w_next = WB;
                end
            end
            M_REQ: begin
                if (lsu_req_ready) begin
                    w_next = M_WAIT;
                end else if (w_expired) begin
                    w_next  = HALT;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            M_WAIT: begin
                if (lsu_rsp_valid) begin
                    w_next = WB;
                end else if (w_expired) begin
                    w_next  = HALT;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            WB: begin
                w_next = F_REQ;
            end
            default: begin
                w_next = HALT;
            end
        endcase
    end

    // Counter restarts when a new bus transaction begins (fetch or memory).
    assign w_wdog_clear = ((w_next == F_REQ) && (r_state != F_REQ)) ||
                          ((w_next == M_REQ) && (r_state != M_REQ));

    // State register plus outputs registered from the next state so every
    // output is a clean flop with no combinational path from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= F_REQ;
            r_pc            <= RESET_PC[XLEN-1:0];
            r_inst          <= '0;
            r_instret       <= '0;
            r_cause         <= '0;
            r_wdog          <= '0;
            r_ifu_req_valid <= 1'b1;
            r_ifu_rsp_ready <= 1'b0;
            r_lsu_req_valid <= 1'b0;
            r_wb_en         <= 1'b0;
            r_halted        <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_cause         <= w_cause;
            r_ifu_req_valid <= (w_next == F_REQ);
            r_ifu_rsp_ready <= (w_next == F_WAIT);
            r_lsu_req_valid <= (w_next == M_REQ);
            r_wb_en         <= (w_next == WB);
            r_halted        <= (w_next == HALT);

            if ((r_state == F_WAIT) && ifu_rsp_valid) begin
                r_inst <= ifu_rsp_data;
            end

            if (r_state == WB) begin
                r_pc      <= exu_dnpc;
                r_instret <= r_instret + CNT_W'(1);
            end

            if (w_wdog_clear) begin
                r_wdog <= '0;
            end else if (w_bus_state) begin
                r_wdog <= r_wdog + TO_W'(1);
            end
        end
    end

    assign ifu_req_valid = r_ifu_req_valid;
    assign ifu_addr      = r_pc;
    assign ifu_rsp_ready = r_ifu_rsp_ready;
    assign inst          = r_inst;
    assign pc            = r_pc;
    assign lsu_req_valid = r_lsu_req_valid;
    assign wb_en         = r_wb_en;
    assign halted        = r_halted;
    assign halt_cause    = r_cause;
    assign instret       = r_instret;

endmodule
